// File: rtl/hls_deadlock_df_monitor.sv
// Dataflow-region deadlock monitor: flags a debounced all-processes-stopped condition with an AXIS stall in it.
// block is registered and rises DEBOUNCE cycles after the condition starts; observation only, so no backpressure.
module hls_deadlock_df_monitor #(
  parameter int NUM_PROC = 5,
  parameter int NUM_AXIS = 5,
  parameter logic [NUM_PROC*NUM_AXIS-1:0] AXIS_MAP = '1,
  parameter int DEBOUNCE = 1,
  parameter int CNT_W = 32,
  parameter int IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] proc_idle_sigs,
  input  logic [NUM_PROC-1:0] proc_chan_block_sigs,
  input  logic [NUM_PROC-1:0] sub_block_sigs,
  output logic                block,
  output logic                block_sticky,
  output logic [IDX_W-1:0]    first_proc_idx,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    event_count
);

  localparam int RUN_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, ARMING, BLOCKED} state_t;

  state_t             state;
  logic [RUN_W-1:0]   run_cnt;
  logic [NUM_PROC-1:0] axis_hit;
  logic [NUM_PROC-1:0] stop;
  logic               cond;
  logic               enter;
  logic [IDX_W-1:0]   low_idx;

  // A process counts as AXIS-blocked only if its child monitor also reports blocked.
  always_comb begin
    axis_hit = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      axis_hit[i] = sub_block_sigs[i] & (|(axis_block_sigs & AXIS_MAP[i*NUM_AXIS +: NUM_AXIS]));
    end
    stop = proc_idle_sigs | proc_chan_block_sigs | axis_hit;
    cond = enable & (|axis_hit) & (&stop);
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (axis_hit[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    enter = 1'b0;
    if (cond) begin
      if (state == IDLE)   enter = (DEBOUNCE == 1);
      if (state == ARMING) enter = (run_cnt == RUN_W'(DEBOUNCE - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      run_cnt        <= '0;
      block          <= 1'b0;
      block_sticky   <= 1'b0;
      first_proc_idx <= '0;
      stall_cycles   <= '0;
      event_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cond) begin
            run_cnt <= RUN_W'(1);
            state   <= (DEBOUNCE == 1) ? BLOCKED : ARMING;
          end
        end
        ARMING: begin
          if (!cond) begin
            state   <= IDLE;
            run_cnt <= '0;
          end else if (enter) begin
            state <= BLOCKED;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        BLOCKED: begin
          if (!cond) begin
            state   <= IDLE;
            run_cnt <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          run_cnt <= '0;
        end
      endcase

      block <= enter | ((state == BLOCKED) & cond);

      if (clear) begin
        block_sticky   <= 1'b0;
        first_proc_idx <= '0;
        stall_cycles   <= '0;
        event_count    <= '0;
      end else if (block && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end

      // A BLOCKED entry in the same cycle as clear takes priority over the clear.
      if (enter) begin
        if (clear)               event_count <= CNT_W'(1);
        else if (!(&event_count)) event_count <= event_count + 1'b1;
        if (clear || !block_sticky) begin
          block_sticky   <= 1'b1;
          first_proc_idx <= low_idx;
        end
      end
    end
  end

endmodule
